// File: rtl/ram_pkg.sv
// Shared types and helpers for the banked Hack data RAM.
package ram_pkg;

   localparam int unsigned HACK_WORD_W = 16;

   typedef enum logic [1:0] {
      RAM_RESET,
      RAM_CLEAR,
      RAM_READY
   } ram_state_t;

   // Bank index is the top sel_w bits of an addr_w-bit word address.
   function automatic int unsigned bank_of(input int unsigned addr,
                                           input int unsigned addr_w,
                                           input int unsigned sel_w);
      return addr >> (addr_w - sel_w);
   endfunction

endpackage

// File: rtl/ram_banked_if.sv
// Request/response bus of ram_banked; master is the CPU memory stage, slave is the RAM.
interface ram_banked_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 6
);

   logic              req_valid;
   logic              req_ready;
   logic              load;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] data_in;
   logic              rd_valid;
   logic [DATA_W-1:0] data_out;
   logic              init_done;

   modport master (
      output req_valid, load, address, data_in,
      input  req_ready, rd_valid, data_out, init_done
   );

   modport slave (
      input  req_valid, load, address, data_in,
      output req_ready, rd_valid, data_out, init_done
   );

endinterface

// File: rtl/ram_bank.sv
// One bank of the banked RAM: synchronous write, registered read every cycle.
module ram_bank #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 3
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_banked.sv
// Banked data RAM with ready/valid requests, 1-cycle registered read and an optional
// post-reset clear pass compiled in with RAM_BANKED_CLEAR_EN.
module ram_banked
   import ram_pkg::*;
#(
   parameter int unsigned DATA_W     = HACK_WORD_W,
   parameter int unsigned ADDR_W     = 6,
   parameter int unsigned BANK_SEL_W = 3
) (
   input logic         clk,
   input logic         rst,
   ram_banked_if.slave bus
);

   localparam int unsigned WordW    = ADDR_W - BANK_SEL_W;
   localparam int unsigned NumBanks = 2**BANK_SEL_W;
   localparam int unsigned Depth    = 2**ADDR_W;

   ram_state_t              state_q, state_d;
   logic                    rd_valid_q, rd_valid_d;
   logic [BANK_SEL_W-1:0]   sel_q, sel_d;
   logic [DATA_W-1:0]       hold_q, hold_d;
`ifdef RAM_BANKED_CLEAR_EN
   logic [ADDR_W-1:0]       clr_q, clr_d;
`endif

   logic                    accept;
   logic                    mem_we;
   logic [ADDR_W-1:0]       mem_addr;
   logic [DATA_W-1:0]       mem_wdata;
   logic [BANK_SEL_W-1:0]   acc_bank;
   logic [DATA_W-1:0]       bank_rdata [NumBanks];
   logic [DATA_W-1:0]       rd_mux;

   assign accept = bus.req_valid && bus.req_ready;

   always_comb begin
      state_d = state_q;
`ifdef RAM_BANKED_CLEAR_EN
      clr_d   = clr_q;
`endif
      unique case (state_q)
         RAM_RESET: begin
`ifdef RAM_BANKED_CLEAR_EN
            state_d = RAM_CLEAR;
            clr_d   = '0;
`else
            state_d = RAM_READY;
`endif
         end
`ifdef RAM_BANKED_CLEAR_EN
         RAM_CLEAR: begin
            clr_d = clr_q + 1'b1;
            if (clr_q == ADDR_W'(Depth - 1)) begin
               state_d = RAM_READY;
            end
         end
`endif
         RAM_READY: state_d = RAM_READY;
         default:   state_d = RAM_RESET;
      endcase
   end

   // The clear engine borrows the write port while it runs; requests are blocked then.
   always_comb begin
      mem_addr  = bus.address;
      mem_wdata = bus.data_in;
      mem_we    = accept && bus.load;
`ifdef RAM_BANKED_CLEAR_EN
      if (state_q == RAM_CLEAR) begin
         mem_addr  = clr_q;
         mem_wdata = '0;
         mem_we    = 1'b1;
      end
`endif
   end

   assign acc_bank = BANK_SEL_W'(bank_of(32'(mem_addr), ADDR_W, BANK_SEL_W));

   for (genvar b = 0; b < NumBanks; b++) begin : g_bank
      ram_bank #(
         .DATA_W (DATA_W),
         .ADDR_W (WordW)
      ) u_bank (
         .clk     (clk),
         .we_i    (mem_we && (acc_bank == BANK_SEL_W'(b))),
         .addr_i  (mem_addr[WordW-1:0]),
         .wdata_i (mem_wdata),
         .rdata_o (bank_rdata[b])
      );
   end

   assign rd_mux = bank_rdata[sel_q];

   always_comb begin
      rd_valid_d = accept && !bus.load;
      sel_d      = rd_valid_d ? acc_bank : sel_q;
      hold_d     = rd_valid_q ? rd_mux : hold_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RAM_RESET;
         rd_valid_q <= 1'b0;
         sel_q      <= '0;
         hold_q     <= '0;
`ifdef RAM_BANKED_CLEAR_EN
         clr_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         rd_valid_q <= rd_valid_d;
         sel_q      <= sel_d;
         hold_q     <= hold_d;
`ifdef RAM_BANKED_CLEAR_EN
         clr_q      <= clr_d;
`endif
      end
   end

   // Outside a response cycle data_out replays the last read word.
   assign bus.data_out  = rd_valid_q ? rd_mux : hold_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.req_ready = (state_q == RAM_READY);
   assign bus.init_done = (state_q == RAM_READY);

endmodule

// File: tb/tb_ram_banked.sv
// Self-checking bench for ram_banked; covers both builds of RAM_BANKED_CLEAR_EN.
module tb_ram_banked;

   localparam int unsigned DW    = 16;
   localparam int unsigned AW    = 6;
   localparam int unsigned BW    = 3;
   localparam int unsigned DEPTH = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   ram_banked_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   ram_banked #(
      .DATA_W     (DW),
      .ADDR_W     (AW),
      .BANK_SEL_W (BW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          total = 0;
   int          bad   = 0;
   logic [15:0] model [DEPTH];
   logic [15:0] exp_last;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic ld, input logic [5:0] a, input logic [15:0] d);
      bus.req_valid = v;
      bus.load      = ld;
      bus.address   = a;
      bus.data_in   = d;
   endtask

`ifdef RAM_BANKED_CLEAR_EN
   task automatic test_reset;
      int early;
      drive(1'b0, 1'b0, 6'h00, 16'h0000);
      rst = 1'b1;
      tick();
      tick();
      total++;
      if (bus.req_ready !== 1'b0 || bus.rd_valid !== 1'b0 || bus.data_out !== 16'h0000 ||
          bus.init_done !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: ready=%b rd_valid=%b data=%h init=%b want 0 0 0000 0",
                  bus.req_ready, bus.rd_valid, bus.data_out, bus.init_done);
      end
      rst   = 1'b0;
      early = 0;
      for (int i = 0; i < 64; i++) begin
         tick();
         if (bus.req_ready !== 1'b0 || bus.init_done !== 1'b0) early++;
      end
      total++;
      if (early != 0) begin
         bad++;
         $display("FAIL clear_ready_low: %0d of 64 clear cycles had ready/init high, want 0", early);
      end
      tick();
      total++;
      if (bus.req_ready !== 1'b1 || bus.init_done !== 1'b1) begin
         bad++;
         $display("FAIL clear_ready_rise: ready=%b init=%b on cycle 65, want 1 1",
                  bus.req_ready, bus.init_done);
      end
      for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
      drive(1'b1, 1'b0, 6'h3F, 16'h0000);
      tick();
      drive(1'b0, 1'b0, 6'h00, 16'h0000);
      total++;
      if (bus.rd_valid !== 1'b1 || bus.data_out !== 16'h0000) begin
         bad++;
         $display("FAIL clear_read_3f: rd_valid=%b data=%h want 1 0000", bus.rd_valid, bus.data_out);
      end
      tick();
      total++;
      if (bus.rd_valid !== 1'b0) begin
         bad++;
         $display("FAIL clear_read_pulse: rd_valid=%b want 0", bus.rd_valid);
      end
      exp_last = 16'h0000;
   endtask

   task automatic test_mid_clear;
      int n;
      int errs;
      drive(1'b0, 1'b0, 6'h00, 16'h0000);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (21) tick();
      rst = 1'b1;
      tick();
      total++;
      if (bus.req_ready !== 1'b0 || bus.rd_valid !== 1'b0) begin
         bad++;
         $display("FAIL midclear_reset: ready=%b rd_valid=%b want 0 0", bus.req_ready, bus.rd_valid);
      end
      rst = 1'b0;
      n   = 0;
      do begin
         tick();
         n++;
      end while (bus.req_ready !== 1'b1 && n < 200);
      total++;
      if (n != 65) begin
         bad++;
         $display("FAIL midclear_restart: ready rose after %0d edges, want 65", n);
      end
      errs = 0;
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 1'b0, 6'(i), 16'h0000);
         tick();
         if (bus.rd_valid !== 1'b1 || bus.data_out !== 16'h0000) errs++;
      end
      drive(1'b0, 1'b0, 6'h00, 16'h0000);
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL midclear_zeroed: %0d of 64 words not read back as 0000, want 0", errs);
      end
      exp_last = 16'h0000;
   endtask
`else
   task automatic test_reset;
      drive(1'b0, 1'b0, 6'h00, 16'h0000);
      rst = 1'b1;
      tick();
      tick();
      total++;
      if (bus.req_ready !== 1'b0 || bus.rd_valid !== 1'b0 || bus.data_out !== 16'h0000 ||
          bus.init_done !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: ready=%b rd_valid=%b data=%h init=%b want 0 0 0000 0",
                  bus.req_ready, bus.rd_valid, bus.data_out, bus.init_done);
      end
      rst = 1'b0;
      tick();
      total++;
      if (bus.req_ready !== 1'b1 || bus.init_done !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready: ready=%b init=%b want 1 1", bus.req_ready, bus.init_done);
      end
      exp_last = 16'h0000;
   endtask

   task automatic test_survive;
      drive(1'b1, 1'b1, 6'h2A, 16'hBEEF);
      tick();
      model[6'h2A] = 16'hBEEF;
      drive(1'b0, 1'b0, 6'h00, 16'h0000);
      rst = 1'b1;
      tick();
      total++;
      if (bus.req_ready !== 1'b0 || bus.rd_valid !== 1'b0 || bus.data_out !== 16'h0000) begin
         bad++;
         $display("FAIL survive_reset: ready=%b rd_valid=%b data=%h want 0 0 0000",
                  bus.req_ready, bus.rd_valid, bus.data_out);
      end
      rst = 1'b0;
      tick();
      total++;
      if (bus.req_ready !== 1'b1) begin
         bad++;
         $display("FAIL survive_ready: ready=%b want 1", bus.req_ready);
      end
      drive(1'b1, 1'b0, 6'h2A, 16'h0000);
      tick();
      drive(1'b0, 1'b0, 6'h00, 16'h0000);
      total++;
      if (bus.rd_valid !== 1'b1 || bus.data_out !== 16'hBEEF) begin
         bad++;
         $display("FAIL survive_read: rd_valid=%b data=%h want 1 beef", bus.rd_valid, bus.data_out);
      end
      exp_last = 16'hBEEF;
      tick();
   endtask
`endif

   task automatic test_fill;
      logic [15:0] d;
      for (int i = 0; i < DEPTH; i++) begin
         d = 16'($urandom);
         drive(1'b1, 1'b1, 6'(i), d);
         tick();
         model[i] = d;
      end
      drive(1'b0, 1'b0, 6'h00, 16'h0000);
      total++;
      if (bus.rd_valid !== 1'b0 || bus.data_out !== exp_last) begin
         bad++;
         $display("FAIL fill_no_resp: rd_valid=%b data=%h want 0 %h",
                  bus.rd_valid, bus.data_out, exp_last);
      end
   endtask

   task automatic test_write_read;
      drive(1'b1, 1'b1, 6'b010100, 16'h1234);
      tick();
      model[6'b010100] = 16'h1234;
      drive(1'b1, 1'b0, 6'b010100, 16'h0000);
      tick();
      drive(1'b0, 1'b0, 6'h00, 16'h0000);
      total++;
      if (bus.rd_valid !== 1'b1 || bus.data_out !== 16'h1234) begin
         bad++;
         $display("FAIL write_read: rd_valid=%b data=%h want 1 1234", bus.rd_valid, bus.data_out);
      end
      tick();
      total++;
      if (bus.rd_valid !== 1'b0 || bus.data_out !== 16'h1234) begin
         bad++;
         $display("FAIL write_read_hold: rd_valid=%b data=%h want 0 1234",
                  bus.rd_valid, bus.data_out);
      end
      exp_last = 16'h1234;
   endtask

   task automatic test_bank_isolation;
      drive(1'b1, 1'b1, 6'h05, 16'hAAAA);
      tick();
      drive(1'b1, 1'b1, 6'h0D, 16'h5555);
      tick();
      model[6'h05] = 16'hAAAA;
      model[6'h0D] = 16'h5555;
      drive(1'b1, 1'b0, 6'h05, 16'h0000);
      tick();
      total++;
      if (bus.rd_valid !== 1'b1 || bus.data_out !== 16'hAAAA) begin
         bad++;
         $display("FAIL bank_iso_05: rd_valid=%b data=%h want 1 aaaa", bus.rd_valid, bus.data_out);
      end
      drive(1'b1, 1'b0, 6'h0D, 16'h0000);
      tick();
      drive(1'b0, 1'b0, 6'h00, 16'h0000);
      total++;
      if (bus.rd_valid !== 1'b1 || bus.data_out !== 16'h5555) begin
         bad++;
         $display("FAIL bank_iso_0d: rd_valid=%b data=%h want 1 5555", bus.rd_valid, bus.data_out);
      end
      exp_last = 16'h5555;
   endtask

   task automatic test_streaming;
      int hits;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b1, 6'(i), 16'(16'h0100 + i));
         tick();
         model[i] = 16'(16'h0100 + i);
      end
      hits = 0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, 6'(i), 16'h0000);
         tick();
         if (bus.rd_valid === 1'b1 && bus.data_out === 16'(16'h0100 + i)) hits++;
      end
      drive(1'b0, 1'b0, 6'h00, 16'h0000);
      total++;
      if (hits != 8) begin
         bad++;
         $display("FAIL streaming: %0d of 8 cycles valid with correct data, want 8", hits);
      end
      tick();
      total++;
      if (bus.rd_valid !== 1'b0 || bus.data_out !== 16'h0107) begin
         bad++;
         $display("FAIL streaming_end: rd_valid=%b data=%h want 0 0107",
                  bus.rd_valid, bus.data_out);
      end
      exp_last = 16'h0107;
   endtask

   task automatic test_random;
      logic        v;
      logic        ld;
      logic [5:0]  a;
      logic [15:0] d;
      logic        exp_v;
      for (int c = 0; c < 400; c++) begin
         v  = 1'($urandom_range(0, 3) != 0);
         ld = 1'($urandom_range(0, 1));
         a  = 6'($urandom);
         d  = 16'($urandom);
         drive(v, ld, a, d);
         tick();
         exp_v = 1'b0;
         if (v && ld) begin
            model[a] = d;
         end else if (v) begin
            exp_v    = 1'b1;
            exp_last = model[a];
         end
         total++;
         if (bus.rd_valid !== exp_v || bus.data_out !== exp_last) begin
            bad++;
            $display("FAIL random cycle %0d: rd_valid=%b data=%h want %b %h",
                     c, bus.rd_valid, bus.data_out, exp_v, exp_last);
         end
      end
      drive(1'b0, 1'b0, 6'h00, 16'h0000);
      tick();
   endtask

   initial begin
      drive(1'b0, 1'b0, 6'h00, 16'h0000);
      exp_last = 16'h0000;
      test_reset();
      test_fill();
      test_write_read();
      test_bank_isolation();
      test_streaming();
`ifdef RAM_BANKED_CLEAR_EN
      test_random();
      test_mid_clear();
`else
      test_survive();
      test_random();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
